// File: rtl/hex_image_streamer.sv
// hex_image_streamer
// Walks the program-image RAM from address 0 and hands the low byte of each
// word to the UART transmitter, one byte per UART transaction. The walk ends
// on the end-of-image marker word, on the last RAM address, or when the UART
// fails to acknowledge a start pulse.
//
// Ports:
//   CLK_UART_i    system/UART clock, rising edge
//   RST_i         synchronous active-high reset
//   start_i       start request (rising edge detected internally)
//   mem_addr_o    RAM read address
//   mem_q_i       RAM read data, valid one cycle after the address is sampled
//   uart_start_o  one-cycle start pulse to UART TX
//   uart_data_o   byte to transmit
//   uart_busy_i   UART TX busy
//   busy_o        streamer active
//   done_o        image finished (held until next accepted start or reset)
//   overrun_o     last address reached without an end marker
//   timeout_o     UART never acknowledged a start pulse
//   byte_count_o  bytes sent since the last accepted start
//
// Build option: define HEX_STREAM_CHECKSUM_EN to append a two's-complement
// checksum byte after the last image byte (end-marker exit only).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a start edge
// READ      | address presented to the RAM
// EVAL      | RAM word valid; end marker check, byte latched
// WAIT_FREE | waiting for the UART to become free
// SEND      | start pulse issued, ack timer loaded
// WAIT_ACK  | waiting for the UART to raise busy
// WAIT_DONE | frame in flight; advance address when busy falls
// DONE      | image finished; a start edge restarts from address 0

module hex_image_streamer #(
  parameter int                ADDR_W      = 10,
  parameter int                DATA_W      = 10,
  parameter int                DEPTH       = 1000,
  parameter logic [DATA_W-1:0] END_MARK    = 10'h1FF,
  parameter int                ACK_TIMEOUT = 15
) (
  input  logic              CLK_UART_i,
  input  logic              RST_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_q_i,
  output logic              uart_start_o,
  output logic [7:0]        uart_data_o,
  input  logic              uart_busy_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o,
  output logic              timeout_o,
  output logic [ADDR_W:0]   byte_count_o
);

  localparam int                ACK_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ACK_W-1:0]  ACK_LOAD  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [ACK_W-1:0]  ACK_ONE   = ACK_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EVAL,
    WAIT_FREE,
    SEND,
    WAIT_ACK,
    WAIT_DONE,
    DONE
  } state_t;

  state_t           state;
  logic             start_q;
  logic             start_armed;
  logic             start_edge;
  logic [ACK_W-1:0] ack_cnt;

`ifdef HEX_STREAM_CHECKSUM_EN
  logic [7:0] sum;
  logic       cks_phase;
`endif

  // start_armed keeps a start_i that is already high when reset lifts from
  // counting as a fresh request; start_i must be seen low first.
  assign start_edge = start_i & ~start_q & start_armed;

  always_ff @(posedge CLK_UART_i) begin
    if (RST_i) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      start_armed  <= ~start_i;
      ack_cnt      <= '0;
      mem_addr_o   <= '0;
      uart_start_o <= 1'b0;
      uart_data_o  <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      overrun_o    <= 1'b0;
      timeout_o    <= 1'b0;
      byte_count_o <= '0;
`ifdef HEX_STREAM_CHECKSUM_EN
      sum          <= '0;
      cks_phase    <= 1'b0;
`endif
    end else begin
      start_q      <= start_i;
      uart_start_o <= 1'b0;
      if (!start_i) start_armed <= 1'b1;

      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            state        <= READ;
            mem_addr_o   <= '0;
            byte_count_o <= '0;
            done_o       <= 1'b0;
            overrun_o    <= 1'b0;
            timeout_o    <= 1'b0;
            busy_o       <= 1'b1;
`ifdef HEX_STREAM_CHECKSUM_EN
            sum          <= '0;
            cks_phase    <= 1'b0;
`endif
          end
        end

        READ: state <= EVAL;

        EVAL: begin
          if (mem_q_i == END_MARK) begin
`ifdef HEX_STREAM_CHECKSUM_EN
            // Checksum byte makes the sum of all sent bytes zero mod 256.
            uart_data_o <= ~sum + 8'd1;
            cks_phase   <= 1'b1;
            state       <= WAIT_FREE;
`else
            state       <= DONE;
            done_o      <= 1'b1;
            busy_o      <= 1'b0;
`endif
          end else begin
            uart_data_o <= mem_q_i[7:0];
            state       <= WAIT_FREE;
          end
        end

        WAIT_FREE: begin
          if (!uart_busy_i) begin
            state        <= SEND;
            uart_start_o <= 1'b1;
          end
        end

        SEND: begin
          ack_cnt <= ACK_LOAD;
          state   <= WAIT_ACK;
`ifdef HEX_STREAM_CHECKSUM_EN
          sum     <= sum + uart_data_o;
`endif
        end

        // Busy wins over the timer: an ack in the last allowed cycle counts.
        WAIT_ACK: begin
          if (uart_busy_i) begin
            state <= WAIT_DONE;
          end else if (ack_cnt == '0) begin
            timeout_o <= 1'b1;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            state     <= DONE;
          end else begin
            ack_cnt <= ack_cnt - ACK_ONE;
          end
        end

        WAIT_DONE: begin
          if (!uart_busy_i) begin
            byte_count_o <= byte_count_o + CNT_ONE;
`ifdef HEX_STREAM_CHECKSUM_EN
            if (cks_phase) begin
              done_o <= 1'b1;
              busy_o <= 1'b0;
              state  <= DONE;
            end else
`endif
            if (mem_addr_o == LAST_ADDR) begin
              overrun_o <= 1'b1;
              done_o    <= 1'b1;
              busy_o    <= 1'b0;
              state     <= DONE;
            end else begin
              mem_addr_o <= mem_addr_o + ADDR_ONE;
              state      <= READ;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_image_streamer.sv
// Testbench for hex_image_streamer: directed table of images plus randomized
// images/UART timing checked against a cycle-level reference model.
module tb_hex_image_streamer;

  localparam int          ADDR_W      = 10;
  localparam int          DATA_W      = 10;
  localparam int          DEPTH       = 4;
  localparam logic [9:0]  END_MARK    = 10'h1FF;
  localparam int          ACK_TIMEOUT = 15;
`ifdef HEX_STREAM_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              start_i;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_q;
  logic              uart_start;
  logic [7:0]        uart_data;
  logic              uart_busy;
  logic              busy_o;
  logic              done_o;
  logic              overrun_o;
  logic              timeout_o;
  logic [ADDR_W:0]   byte_count;

  hex_image_streamer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .END_MARK(END_MARK), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .CLK_UART_i(clk),
    .RST_i(rst),
    .start_i(start_i),
    .mem_addr_o(mem_addr),
    .mem_q_i(mem_q),
    .uart_start_o(uart_start),
    .uart_data_o(uart_data),
    .uart_busy_i(uart_busy),
    .busy_o(busy_o),
    .done_o(done_o),
    .overrun_o(overrun_o),
    .timeout_o(timeout_o),
    .byte_count_o(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][9:0] w;
    logic [7:0]      d;      // cycles before busy rises after the pulse; >=100 never
    logic [7:0]      len;    // busy length
    logic            glitch; // extra start edge while running
    logic [7:0]      cnt;
    logic            ovr;
    logic            to;
    logic [7:0]      addr;
    logic [7:0]      np;
    logic [3:0][7:0] b;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // RAM and UART models
  logic [9:0] ram [0:3];
  int         ack_delay = 0;
  int         busy_len  = 1;
  int         pend      = 0;
  int         busy_left = 0;
  logic [7:0] tx_q[$];
  int         tx_c[$];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    mem_q <= ram[mem_addr[1:0]];
    if (uart_start) begin
      tx_q.push_back(uart_data);
      tx_c.push_back(cyc);
      if (ack_delay == 0) begin
        uart_busy <= 1'b1;
        busy_left <= busy_len;
      end else if (ack_delay < 100) begin
        pend <= ack_delay;
      end
    end else if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        uart_busy <= 1'b1;
        busy_left <= busy_len;
      end
    end else if (uart_busy) begin
      busy_left <= busy_left - 1;
      if (busy_left <= 1) uart_busy <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: expected bytes, pulse cycles and done cycle relative to
  // the cycle in which the start edge is sampled.
  logic [7:0] e_bytes[$];
  int         e_pc[$];
  int         e_cnt, e_addr, e_done;
  bit         e_ovr, e_to;

  task automatic build_expect(input vec_t v);
    int c, a, p, free_c;
    logic [7:0] sum, b;
    bit is_end;
    e_bytes.delete(); e_pc.delete();
    e_cnt = 0; e_ovr = 0; e_to = 0; e_addr = 0; e_done = 0;
    c = 2; a = 0; sum = 8'h00;
    for (int guard = 0; guard < 8; guard++) begin
      is_end = (v.w[a] == END_MARK);
      e_addr = a;
      if (is_end && !CKS_EN) begin e_done = c + 1; break; end
      b = is_end ? (8'h00 - sum) : v.w[a][7:0];
      p = c + 2;
      e_bytes.push_back(b);
      e_pc.push_back(p);
      if (int'(v.d) >= ACK_TIMEOUT) begin e_to = 1; e_done = p + ACK_TIMEOUT + 1; break; end
      sum = sum + b;
      e_cnt++;
      free_c = p + int'(v.d) + int'(v.len) + 1;
      if (is_end) begin e_done = free_c + 1; break; end
      if (a == DEPTH - 1) begin e_ovr = 1; e_done = free_c + 1; break; end
      a++;
      c = free_c + 2;
    end
  endtask

  function automatic vec_t mk(input logic [9:0] w0, w1, w2, w3, input int d, len, cnt,
                              input bit ovr, to, input int addr, np,
                              input logic [7:0] b0, b1, b2, b3);
    vec_t v;
    v.w = {w3, w2, w1, w0};
    v.d = 8'(d); v.len = 8'(len); v.glitch = 1'b0;
    v.cnt = 8'(cnt); v.ovr = ovr; v.to = to; v.addr = 8'(addr); v.np = 8'(np);
    v.b = {b3, b2, b1, b0};
    return v;
  endfunction

  task automatic run_case(input vec_t v, input string tag);
    int n0, t, nmin;
    bit seen, gl;
    for (int i = 0; i < 4; i++) ram[i] = v.w[i];
    ack_delay = int'(v.d);
    busy_len  = int'(v.len);
    build_expect(v);
    t = 0;
    while ((uart_busy || pend != 0) && t < 400) begin @(negedge clk); t++; end
    tx_q.delete(); tx_c.delete();
    @(negedge clk);
    start_i = 1'b1;
    n0 = cyc;
    @(negedge clk);
    start_i = 1'b0;
    chk({tag, " busy_o_running"}, busy_o, 1);
    chk({tag, " done_cleared"}, done_o, 0);
    seen = 0; gl = 0;
    for (t = 0; t < 800; t++) begin
      if (done_o) begin seen = 1; break; end
      if (v.glitch && !gl && tx_q.size() > 0) begin start_i = 1'b1; gl = 1; end
      else start_i = 1'b0;
      @(negedge clk);
    end
    start_i = 1'b0;
    chk({tag, " done_seen"}, seen, 1);
    chk({tag, " done_cycle"}, cyc - n0, e_done);
    repeat (3) @(negedge clk);
    chk({tag, " done_held"}, done_o, 1);
    chk({tag, " busy_o_end"}, busy_o, 0);
    chk({tag, " byte_count"}, byte_count, v.cnt);
    chk({tag, " overrun"}, overrun_o, v.ovr);
    chk({tag, " timeout"}, timeout_o, v.to);
    chk({tag, " mem_addr"}, mem_addr, v.addr);
    chk({tag, " pulses"}, tx_q.size(), v.np);
    nmin = (tx_q.size() < int'(v.np)) ? tx_q.size() : int'(v.np);
    for (int i = 0; i < nmin; i++) chk({tag, " byte"}, tx_q[i], v.b[i]);
    nmin = (tx_c.size() < e_pc.size()) ? tx_c.size() : e_pc.size();
    for (int i = 0; i < nmin; i++) chk({tag, " pulse_cycle"}, tx_c[i] - n0, e_pc[i]);
  endtask

  vec_t tbl[9];

  initial begin
    int t, r;
    vec_t v;
    rst = 1'b1; start_i = 1'b0; uart_busy = 1'b0;
    for (int i = 0; i < 4; i++) ram[i] = 10'h000;

    tbl[0] = mk(10'h03A, 10'h155, 10'h1FF, 10'h000, 0, 20, CKS_EN ? 3 : 2, 0, 0, 2,
                CKS_EN ? 3 : 2, 8'h3A, 8'h55, CKS_EN ? 8'h71 : 8'h00, 8'h00);
    tbl[1] = mk(10'h1FF, 10'h000, 10'h000, 10'h000, 0, 20, CKS_EN ? 1 : 0, 0, 0, 0,
                CKS_EN ? 1 : 0, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[2] = mk(10'h001, 10'h002, 10'h003, 10'h004, 0, 20, 4, 1, 0, 3, 4,
                8'h01, 8'h02, 8'h03, 8'h04);
    tbl[3] = mk(10'h03A, 10'h155, 10'h1FF, 10'h000, 200, 5, 0, 0, 1, 0, 1,
                8'h3A, 8'h00, 8'h00, 8'h00);
    tbl[4] = mk(10'h010, 10'h020, 10'h1FF, 10'h000, 2, 3, CKS_EN ? 3 : 2, 0, 0, 2,
                CKS_EN ? 3 : 2, 8'h10, 8'h20, CKS_EN ? 8'hD0 : 8'h00, 8'h00);
    tbl[5] = mk(10'h0FF, 10'h3FF, 10'h1FF, 10'h000, 1, 1, CKS_EN ? 3 : 2, 0, 0, 2,
                CKS_EN ? 3 : 2, 8'hFF, 8'hFF, CKS_EN ? 8'h02 : 8'h00, 8'h00);
    tbl[6] = mk(10'h155, 10'h1FF, 10'h000, 10'h000, 14, 2, CKS_EN ? 2 : 1, 0, 0, 1,
                CKS_EN ? 2 : 1, 8'h55, CKS_EN ? 8'hAB : 8'h00, 8'h00, 8'h00);
    tbl[7] = mk(10'h0AA, 10'h0BB, 10'h0CC, 10'h1FF, 15, 2, 0, 0, 1, 0, 1,
                8'hAA, 8'h00, 8'h00, 8'h00);
    tbl[8] = mk(10'h0AA, 10'h0BB, 10'h0CC, 10'h1FF, 0, 1, CKS_EN ? 4 : 3, 0, 0, 3,
                CKS_EN ? 4 : 3, 8'hAA, 8'hBB, 8'hCC, CKS_EN ? 8'hCF : 8'h00);
    tbl[2].glitch = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset uart_start", uart_start, 0);
    chk("reset uart_data", uart_data, 0);
    chk("reset busy_o", busy_o, 0);
    chk("reset done_o", done_o, 0);
    chk("reset overrun", overrun_o, 0);
    chk("reset timeout", timeout_o, 0);
    chk("reset byte_count", byte_count, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 9; k++) run_case(tbl[k], $sformatf("tbl%0d", k));

    // Reset while a frame is in flight, with start_i held high across it.
    for (int i = 0; i < 4; i++) ram[i] = tbl[2].w[i];
    ack_delay = 0; busy_len = 20;
    tx_q.delete(); tx_c.delete();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    t = 0;
    while (!uart_busy && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("rst_mid in_wait_done", busy_o, 1);
    rst = 1'b1; start_i = 1'b1;
    @(negedge clk);
    chk("rst_mid mem_addr", mem_addr, 0);
    chk("rst_mid uart_start", uart_start, 0);
    chk("rst_mid uart_data", uart_data, 0);
    chk("rst_mid busy_o", busy_o, 0);
    chk("rst_mid done_o", done_o, 0);
    chk("rst_mid overrun", overrun_o, 0);
    chk("rst_mid timeout", timeout_o, 0);
    chk("rst_mid byte_count", byte_count, 0);
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_mid held_start busy_o", busy_o, 0);
    chk("rst_mid held_start pulses", tx_q.size(), 1);
    start_i = 1'b0;
    @(negedge clk);
    v = tbl[2]; v.glitch = 1'b0;
    run_case(v, "rst_restart");

    // Randomized images and UART timing against the reference model.
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 4; i++)
        v.w[i] = ($urandom_range(0, 3) == 0) ? END_MARK : 10'($urandom_range(0, 1023));
      r = $urandom_range(0, 9);
      v.d = (r == 0) ? 8'd200 : (r == 1) ? 8'($urandom_range(15, 17)) : 8'($urandom_range(0, 14));
      v.len = 8'($urandom_range(1, 8));
      v.glitch = 1'($urandom_range(0, 1));
      build_expect(v);
      v.cnt = 8'(e_cnt); v.ovr = e_ovr; v.to = e_to; v.addr = 8'(e_addr);
      v.np = 8'(e_bytes.size());
      v.b = '0;
      for (int i = 0; i < e_bytes.size() && i < 4; i++) v.b[i] = e_bytes[i];
      run_case(v, $sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
